// File: rtl/jt51_decim.sv
// jt51_decim: stereo 2nd-order CIC decimator by R = 2**LOG2R.
// Two integrators run at the input strobe rate. The comb stage and the output
// scaling run once per R input samples. The comb fires in the cycle after the
// last sample of a frame, and sample_out follows one cycle later.
// Build option: define JT51_DECIM_ROUND_EN to round half up before the final
// shift. When it is undefined, the shift truncates toward -inf.
module jt51_decim #(
    parameter int LOG2R = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_in,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        sample_out
);

    localparam int W  = 16 + 2*LOG2R;
    localparam int SH = 2*LOG2R;
    localparam logic [LOG2R-1:0] PH_LAST = '1;
`ifdef JT51_DECIM_ROUND_EN
    localparam logic [W-1:0] RND = W'(1) << (SH-1);
`endif

    // The CIC gain is R**2, so the shift by 2*LOG2R brings c2 back into 16 bits.
    function automatic logic [15:0] scale(input logic [W-1:0] c2);
        logic [W-1:0] biased;
`ifdef JT51_DECIM_ROUND_EN
        biased = c2 + RND;
`else
        biased = c2;
`endif
        return 16'($signed(biased) >>> SH);
    endfunction

    logic [W-1:0]     int1_l_q, int1_l_d, int2_l_q, int2_l_d;
    logic [W-1:0]     int1_r_q, int1_r_d, int2_r_q, int2_r_d;
    logic [W-1:0]     d1_l_q, d1_l_d, d2_l_q, d2_l_d;
    logic [W-1:0]     d1_r_q, d1_r_d, d2_r_q, d2_r_d;
    logic [LOG2R-1:0] phase_q, phase_d;
    logic             dec_stb_q, dec_stb_d;
    logic [15:0]      out_l_q, out_l_d, out_r_q, out_r_d;
    logic             sample_out_q, sample_out_d;

    logic [W-1:0]     x_l, x_r;
    logic [W-1:0]     c1_l, c2_l, c1_r, c2_r;

    // Next-state logic: integrate on each input strobe, and comb/scale on the decimation strobe.
    always_comb begin
        x_l = {{(W-16){left_in[15]}},  left_in};
        x_r = {{(W-16){right_in[15]}}, right_in};

        // The comb reads int2 as registered. A sample arriving in the same
        // cycle updates the integrators and belongs to the next frame.
        c1_l = int2_l_q - d1_l_q;
        c2_l = c1_l - d2_l_q;
        c1_r = int2_r_q - d1_r_q;
        c2_r = c1_r - d2_r_q;

        int1_l_d     = int1_l_q;
        int2_l_d     = int2_l_q;
        int1_r_d     = int1_r_q;
        int2_r_d     = int2_r_q;
        d1_l_d       = d1_l_q;
        d2_l_d       = d2_l_q;
        d1_r_d       = d1_r_q;
        d2_r_d       = d2_r_q;
        phase_d      = phase_q;
        dec_stb_d    = 1'b0;
        out_l_d      = out_l_q;
        out_r_d      = out_r_q;
        sample_out_d = dec_stb_q;

        if (sample_in) begin
            int1_l_d  = int1_l_q + x_l;
            int2_l_d  = int2_l_q + int1_l_q;
            int1_r_d  = int1_r_q + x_r;
            int2_r_d  = int2_r_q + int1_r_q;
            phase_d   = phase_q + LOG2R'(1);
            dec_stb_d = (phase_q == PH_LAST);
        end

        if (dec_stb_q) begin
            d1_l_d  = int2_l_q;
            d2_l_d  = c1_l;
            out_l_d = scale(c2_l);
            d1_r_d  = int2_r_q;
            d2_r_d  = c1_r;
            out_r_d = scale(c2_r);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int1_l_q     <= '0;
            int2_l_q     <= '0;
            int1_r_q     <= '0;
            int2_r_q     <= '0;
            d1_l_q       <= '0;
            d2_l_q       <= '0;
            d1_r_q       <= '0;
            d2_r_q       <= '0;
            phase_q      <= '0;
            dec_stb_q    <= 1'b0;
            out_l_q      <= '0;
            out_r_q      <= '0;
            sample_out_q <= 1'b0;
        end else begin
            int1_l_q     <= int1_l_d;
            int2_l_q     <= int2_l_d;
            int1_r_q     <= int1_r_d;
            int2_r_q     <= int2_r_d;
            d1_l_q       <= d1_l_d;
            d2_l_q       <= d2_l_d;
            d1_r_q       <= d1_r_d;
            d2_r_q       <= d2_r_d;
            phase_q      <= phase_d;
            dec_stb_q    <= dec_stb_d;
            out_l_q      <= out_l_d;
            out_r_q      <= out_r_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign out_l      = out_l_q;
    assign out_r      = out_r_q;
    assign sample_out = sample_out_q;

endmodule

// File: tb/tb_jt51_decim.sv
// Directed testbench for jt51_decim.
// The main instance uses LOG2R=2. Two extra instances, with LOG2R=1 and
// LOG2R=4, share the same inputs and are used for the strobe-timing checks.
module tb_jt51_decim;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_in = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic [15:0] out_l, out_r, out_l_r2, out_r_r2, out_l_r16, out_r_r16;
    logic        sample_out, sample_out_r2, sample_out_r16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jt51_decim #(.LOG2R(2)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
        .left_in(left_in), .right_in(right_in),
        .out_l(out_l), .out_r(out_r), .sample_out(sample_out)
    );

    jt51_decim #(.LOG2R(1)) dut_r2 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
        .left_in(left_in), .right_in(right_in),
        .out_l(out_l_r2), .out_r(out_r_r2), .sample_out(sample_out_r2)
    );

    jt51_decim #(.LOG2R(4)) dut_r16 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in),
        .left_in(left_in), .right_in(right_in),
        .out_l(out_l_r16), .out_r(out_r_r16), .sample_out(sample_out_r16)
    );

    // Advance one clock and settle past the edge before sampling outputs.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        sample_in = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sample_in = 1'b1;
        left_in = 16'd1234;
        right_in = 16'(-1234);
        tick;
        tick;
        checks++; if (out_l !== 16'd0) begin errors++; $display("FAIL reset_out_l: got %0d expected 0", $signed(out_l)); end
        checks++; if (out_r !== 16'd0) begin errors++; $display("FAIL reset_out_r: got %0d expected 0", $signed(out_r)); end
        checks++; if (sample_out !== 1'b0) begin errors++; $display("FAIL reset_sample_out: got %b expected 0", sample_out); end
        checks++; if ({out_l_r2, out_r_r2, sample_out_r2} !== 33'd0) begin errors++; $display("FAIL reset_r2: got %h expected 0", {out_l_r2, out_r_r2, sample_out_r2}); end
        checks++; if ({out_l_r16, out_r_r16, sample_out_r16} !== 33'd0) begin errors++; $display("FAIL reset_r16: got %h expected 0", {out_l_r16, out_r_r16, sample_out_r16}); end
        // Samples offered during reset must be ignored. Four zero samples after release must yield zero.
        rst_n = 1'b1;
        left_in = '0;
        right_in = '0;
        for (int e = 1; e <= 6; e++) begin
            sample_in = (e <= 4);
            tick;
            if (e == 5) begin
                checks++; if (sample_out !== 1'b1) begin errors++; $display("FAIL reset_first_strobe: got %b expected 1", sample_out); end
                checks++; if (out_l !== 16'd0) begin errors++; $display("FAIL reset_ignored_l: got %0d expected 0", $signed(out_l)); end
                checks++; if (out_r !== 16'd0) begin errors++; $display("FAIL reset_ignored_r: got %0d expected 0", $signed(out_r)); end
            end
            if (e == 6) begin
                checks++; if (sample_out !== 1'b0) begin errors++; $display("FAIL reset_strobe_width: got %b expected 0", sample_out); end
            end
        end
    endtask

    task automatic test_impulse(input int val, input int nexp, input int exp_l[4], input int exp_r[4]);
        logic [15:0] got_l [4];
        logic [15:0] got_r [4];
        int n;
        int first_e;
        apply_reset;
        n = 0;
        first_e = 0;
        for (int e = 1; e <= 60 && n < nexp; e++) begin
            sample_in = 1'b1;
            left_in  = (e == 1) ? 16'(val)  : 16'd0;
            right_in = (e == 1) ? 16'(-val) : 16'd0;
            tick;
            if (sample_out === 1'b1) begin
                got_l[n] = out_l;
                got_r[n] = out_r;
                if (n == 0) first_e = e;
                n++;
            end
        end
        sample_in = 1'b0;
        checks++; if (n != nexp) begin errors++; $display("FAIL impulse%0d_count: got %0d expected %0d", val, n, nexp); end
        checks++; if (first_e != 5) begin errors++; $display("FAIL impulse%0d_latency: got edge %0d expected 5", val, first_e); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got_l[k] !== 16'(exp_l[k])) begin errors++; $display("FAIL impulse%0d_l[%0d]: got %0d expected %0d", val, k, $signed(got_l[k]), exp_l[k]); end
            checks++; if (got_r[k] !== 16'(exp_r[k])) begin errors++; $display("FAIL impulse%0d_r[%0d]: got %0d expected %0d", val, k, $signed(got_r[k]), exp_r[k]); end
        end
    endtask

    task automatic test_dc;
        int exp_l [5];
        logic [15:0] got_l [5];
        logic [15:0] got_r [5];
        int edge_at [5];
        int n;
        exp_l = '{375, 1000, 1000, 1000, 1000};
        apply_reset;
        n = 0;
        sample_in = 1'b1;
        left_in = 16'd1000;
        right_in = 16'(-1000);
        for (int e = 1; e <= 100 && n < 5; e++) begin
            tick;
            if (sample_out === 1'b1) begin
                got_l[n] = out_l;
                got_r[n] = out_r;
                edge_at[n] = e;
                n++;
            end
        end
        sample_in = 1'b0;
        checks++; if (n != 5) begin errors++; $display("FAIL dc_count: got %0d expected 5", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got_l[k] !== 16'(exp_l[k])) begin errors++; $display("FAIL dc_l[%0d]: got %0d expected %0d", k, $signed(got_l[k]), exp_l[k]); end
            checks++; if (got_r[k] !== 16'(-exp_l[k])) begin errors++; $display("FAIL dc_r[%0d]: got %0d expected %0d", k, $signed(got_r[k]), -exp_l[k]); end
            if (k > 0) begin
                checks++; if (edge_at[k] - edge_at[k-1] != 4) begin errors++; $display("FAIL dc_spacing[%0d]: got %0d expected 4", k, edge_at[k] - edge_at[k-1]); end
            end
        end
    endtask

    // Runs right after test_dc. One sample of the next frame has already been taken.
    task automatic test_hold;
        int first_e;
        for (int c = 0; c < 20; c++) begin
            sample_in = 1'b0;
            tick;
            checks++; if (out_l !== 16'd1000 || out_r !== 16'(-1000) || sample_out !== 1'b0) begin
                errors++; $display("FAIL hold[%0d]: got l=%0d r=%0d so=%b expected l=1000 r=-1000 so=0", c, $signed(out_l), $signed(out_r), sample_out);
            end
        end
        first_e = 0;
        left_in = 16'd1000;
        right_in = 16'(-1000);
        for (int e = 1; e <= 10 && first_e == 0; e++) begin
            sample_in = 1'b1;
            tick;
            if (sample_out === 1'b1) first_e = e;
        end
        sample_in = 1'b0;
        checks++; if (first_e != 4) begin errors++; $display("FAIL hold_resume_latency: got edge %0d expected 4", first_e); end
        checks++; if (out_l !== 16'd1000) begin errors++; $display("FAIL hold_resume_l: got %0d expected 1000", $signed(out_l)); end
    endtask

    task automatic test_full_scale;
        logic [15:0] got_l [5];
        logic [15:0] got_r [5];
        int edge_at [5];
        int n;
        apply_reset;
        n = 0;
        left_in = 16'h8000;
        right_in = 16'h7fff;
        for (int e = 1; e <= 200 && n < 5; e++) begin
            sample_in = ((e - 1) % 3 == 0);
            tick;
            if (sample_out === 1'b1) begin
                got_l[n] = out_l;
                got_r[n] = out_r;
                edge_at[n] = e;
                n++;
            end
        end
        sample_in = 1'b0;
        checks++; if (n != 5) begin errors++; $display("FAIL fs_count: got %0d expected 5", n); end
        checks++; if (edge_at[0] != 11) begin errors++; $display("FAIL fs_latency: got edge %0d expected 11", edge_at[0]); end
        for (int k = 1; k < n; k++) begin
            checks++; if (got_l[k] !== 16'h8000) begin errors++; $display("FAIL fs_l[%0d]: got %0d expected -32768", k, $signed(got_l[k])); end
            checks++; if (got_r[k] !== 16'h7fff) begin errors++; $display("FAIL fs_r[%0d]: got %0d expected 32767", k, $signed(got_r[k])); end
            checks++; if (edge_at[k] - edge_at[k-1] != 12) begin errors++; $display("FAIL fs_spacing[%0d]: got %0d expected 12", k, edge_at[k] - edge_at[k-1]); end
        end
    endtask

    task automatic test_reset_mid;
        int exp_l [3];
        logic [15:0] got_l [3];
        logic [15:0] got_r [3];
        int edge_at [3];
        int n;
        exp_l = '{75, 200, 200};
        sample_in = 1'b1;
        left_in = 16'd5000;
        right_in = 16'd5000;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        checks++; if (out_l !== 16'd0 || out_r !== 16'd0) begin errors++; $display("FAIL midreset_out: got l=%0d r=%0d expected 0 0", $signed(out_l), $signed(out_r)); end
        checks++; if (sample_out !== 1'b0) begin errors++; $display("FAIL midreset_sample_out: got %b expected 0", sample_out); end
        rst_n = 1'b1;
        left_in = 16'd200;
        right_in = 16'(-200);
        n = 0;
        for (int e = 1; e <= 40 && n < 3; e++) begin
            tick;
            if (sample_out === 1'b1) begin
                got_l[n] = out_l;
                got_r[n] = out_r;
                edge_at[n] = e;
                n++;
            end
        end
        sample_in = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL midreset_count: got %0d expected 3", n); end
        checks++; if (edge_at[0] != 5) begin errors++; $display("FAIL midreset_phase: got edge %0d expected 5", edge_at[0]); end
        for (int k = 0; k < n; k++) begin
            checks++; if (got_l[k] !== 16'(exp_l[k])) begin errors++; $display("FAIL midreset_l[%0d]: got %0d expected %0d", k, $signed(got_l[k]), exp_l[k]); end
            checks++; if (got_r[k] !== 16'(-exp_l[k])) begin errors++; $display("FAIL midreset_r[%0d]: got %0d expected %0d", k, $signed(got_r[k]), -exp_l[k]); end
        end
    endtask

    // Sample j is taken at edge j+1, so a phase R-1 sample gives sample_out after edge j+2.
    task automatic test_timing;
        logic exp2, exp4, exp16;
        int j;
        apply_reset;
        left_in = '0;
        right_in = '0;
        for (int e = 1; e <= 22; e++) begin
            sample_in = (e <= 16);
            tick;
            j = e - 2;
            exp2  = (j >= 0) && (j < 16) && (j % 2  == 1);
            exp4  = (j >= 0) && (j < 16) && (j % 4  == 3);
            exp16 = (j >= 0) && (j < 16) && (j % 16 == 15);
            checks++; if (sample_out !== exp4) begin errors++; $display("FAIL timing_r4 edge %0d: got %b expected %b", e, sample_out, exp4); end
            checks++; if (sample_out_r2 !== exp2) begin errors++; $display("FAIL timing_r2 edge %0d: got %b expected %b", e, sample_out_r2, exp2); end
            checks++; if (sample_out_r16 !== exp16) begin errors++; $display("FAIL timing_r16 edge %0d: got %b expected %b", e, sample_out_r16, exp16); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int il [4];
        int ir [4];
        test_reset;
        il = '{3, 1, 0, 0};
        ir = '{-3, -1, 0, 0};
        test_impulse(16, 4, il, ir);
`ifdef JT51_DECIM_ROUND_EN
        il = '{2, 1, 0, 0};
        ir = '{-1, 0, 0, 0};
`else
        il = '{1, 0, 0, 0};
        ir = '{-2, -1, 0, 0};
`endif
        test_impulse(8, 3, il, ir);
        test_dc;
        test_hold;
        test_full_scale;
        test_reset_mid;
        test_timing;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
